booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised, sequential, signed radix-2 Booth multiplier with a start/done handshake.
- Successor to the single-cycle 8-bit combinational Booth multiplier. Operand width is now generic, and the datapath iterates one recoded bit per clock to trade latency for area.
- Used by datapath blocks that need an NxN signed multiply without a full array multiplier.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32. A value outside this range is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request pulse; sampled only when the block can accept (see Behaviour).
- multiplicand  in  WIDTH  signed operand M; sampled with an accepted start.
- multiplier  in  WIDTH  signed operand Q; sampled with an accepted start.
- busy  out  1  high while an operation is in progress (state CALC).
- done  out  1  single-cycle pulse; product valid.
- product  out  2*WIDTH  signed result M*Q; held until the next accepted start.

Behaviour:
- Reset: on a clk edge with rst_n=0, go to IDLE with busy=0, done=0, product=0, all internal registers 0. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CALC, DONE.
- Start acceptance:
  - start is accepted when state is IDLE or DONE; operands are latched on that edge.
  - In CALC, start is ignored and the operands are not re-sampled.
  - An accepted start in DONE enables back-to-back operations with no idle cycle.
- On accept:
  - A (WIDTH+1 bits, sign-extended accumulator) = 0; Qreg = multiplier; q_m1 = 0.
  - M latched and sign-extended to WIDTH+1 bits; cnt = WIDTH; state goes to CALC.
- Each CALC edge:
  - Recode {Qreg[0], q_m1}: 01 gives A+M, 10 gives A−M, 00/11 leaves A unchanged.
  - Then arithmetic right shift of {A, Qreg, q_m1} by 1, and cnt decrements.
  - A is WIDTH+1 bits so −M for M = −2^(WIDTH−1) cannot overflow.
- When cnt reaches 0 on an edge:
  - product <= {A[WIDTH−1:0], Qreg}; state goes to DONE.
- Latency:
  - start sampled at edge N gives done=1 in the cycle after edge N+WIDTH, for exactly one cycle.
  - busy=1 in the cycles after edges N..N+WIDTH−1.
- DONE goes to IDLE on the next edge, unless start is accepted, in which case it goes to CALC.
- The result is exact for all operand pairs, including −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2*WIDTH−2). No saturation and no overflow flag.
- product is stable outside the DONE-entry edge; it never changes during CALC.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined:
  - Radix-4 modified Booth recoding on {Qreg[1:0], q_m1}, giving ops 0, ±M, ±2M.
  - Shift by 2 per cycle; A widened to WIDTH+2 bits.
  - cnt starts at WIDTH/2, so done occurs WIDTH/2 edges after the accepting edge.
  - WIDTH must be even; odd WIDTH is an elaboration error.
- Undefined: radix-2 exactly as above.
- Results are identical in both modes; only latency differs.

Decomposition:
- Package booth_pkg holds:
  - state enum typedef (IDLE, CALC, DONE);
  - recode-op enum (OP_NONE, OP_ADD, OP_SUB, OP_ADD2, OP_SUB2);
  - function iter_count(width) returning WIDTH or WIDTH/2 according to the macro.
- Sub-module booth_recoder: combinational. Takes the recode bit window and returns the op enum. Shared by both modes, with the 2M ops unused in radix-2.
- The top module holds the FSM, counter, accumulator/shift datapath and output registers.

Test Plan:
- WIDTH=8: M=127, Q=−1, start pulse → done exactly 8 cycles after accept (4 with BOOTH_RADIX4_EN), product=−127, busy high for 8 cycles.
- WIDTH=8: pairs (−128,−128) → 16384; (−128,1) → −128; (0,85) → 0; (5,5) → 25; (64,2) → 128.
- WIDTH=8: start held high continuously with new operands (3,−7) then (−9,11) → start re-accepted in the DONE cycle, products −21 then −99, with no IDLE cycle between.
- WIDTH=8: start with (10,10), then start pulsed with (2,2) at cycle 3 of CALC → ignored, product=100, one done pulse only.
- WIDTH=8: rst_n=0 for one cycle at cycle 4 of CALC → no done, busy=0, product=0; a fresh start (6,−6) gives −36.
- WIDTH=16: (−32768,−32768) → 1073741824; (32767,−32768) → −1073709056; latency 16 (8 with radix-4). Finish with a 1000-vector random sweep against the reference model multiplicand*multiplier.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Optional feature: define BOOTH_RADIX4_EN for radix-4 modified Booth recoding
// (two multiplier bits retired per clock instead of one).
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_ADD2 = 3'd3,
        OP_SUB2 = 3'd4
    } op_e;

`ifdef BOOTH_RADIX4_EN
    localparam int BITS_PER_ITER = 2;
`else
    localparam int BITS_PER_ITER = 1;
`endif

    // Number of CALC iterations needed to retire all multiplier bits.
    function automatic int iter_count(input int width);
        iter_count = width / BITS_PER_ITER;
    endfunction

endpackage

// File: rtl/booth_mult_seq_recoder.sv
// Booth recoder: maps a 3-bit multiplier window {b1, b0, b-1} to an
// accumulator operation. Radix-2 callers replicate b0 into b1 so that only
// the NONE/ADD/SUB codes can appear.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] i_window,
    output op_e        o_op
);

    // Standard modified-Booth recoding table.
    always_comb begin
        o_op = OP_NONE;
        case (i_window)
            3'b000, 3'b111: o_op = OP_NONE;
            3'b001, 3'b010: o_op = OP_ADD;
            3'b011:         o_op = OP_ADD2;
            3'b100:         o_op = OP_SUB2;
            3'b101, 3'b110: o_op = OP_SUB;
            default:        o_op = OP_NONE;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier with start/done handshake.
// Radix-2 by default (WIDTH iterations); define BOOTH_RADIX4_EN for
// radix-4 recoding (WIDTH/2 iterations, WIDTH must be even).
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [WIDTH-1:0]     multiplicand,
    input  logic signed [WIDTH-1:0]     multiplier,
    output logic                        busy,
    output logic                        done,
    output logic signed [2*WIDTH-1:0]   product
);

    // Accumulator carries extra sign bits so -M and -2M of the most
    // negative operand never overflow.
    localparam int AW   = WIDTH + BITS_PER_ITER;
    localparam int ITER = iter_count(WIDTH);
    localparam int CW   = $clog2(WIDTH + 1);

    if ((WIDTH < 4) || (WIDTH > 32)) begin : g_bad_width
        $error("booth_mult_seq: WIDTH must be in 4..32");
    end

`ifdef BOOTH_RADIX4_EN
    if ((WIDTH % 2) != 0) begin : g_odd_width
        $error("booth_mult_seq: radix-4 mode needs an even WIDTH");
    end
`endif

    state_e                     r_state;
    logic [AW-1:0]              r_acc;
    logic [AW-1:0]              r_mcand;
    logic [WIDTH-1:0]           r_qreg;
    logic                       r_qm1;
    logic [CW-1:0]              r_cnt;
    logic                       r_busy;
    logic                       r_done;
    logic signed [2*WIDTH-1:0]  r_product;

    logic [2:0]                 w_window;
    op_e                        w_op;
    logic [AW-1:0]              w_m2;
    logic [AW-1:0]              w_addend;
    logic [AW-1:0]              w_sum;
    logic [AW-1:0]              w_acc_next;
    logic [WIDTH-1:0]           w_q_next;
    logic                       w_qm1_next;

`ifdef BOOTH_RADIX4_EN
    assign w_window = {r_qreg[1:0], r_qm1};
`else
    assign w_window = {r_qreg[0], r_qreg[0], r_qm1};
`endif

    booth_recoder u_recoder (
        .i_window (w_window),
        .o_op     (w_op)
    );

    assign w_m2  = {r_mcand[AW-2:0], 1'b0};
    assign w_sum = r_acc + w_addend;

    // Select the accumulator addend for the recoded operation.
    always_comb begin
        w_addend = {AW{1'b0}};
        case (w_op)
            OP_NONE: w_addend = {AW{1'b0}};
            OP_ADD:  w_addend = r_mcand;
            OP_SUB:  w_addend = -r_mcand;
            OP_ADD2: w_addend = w_m2;
            OP_SUB2: w_addend = -w_m2;
            default: w_addend = {AW{1'b0}};
        endcase
    end

    // Arithmetic right shift of {A, Qreg, q_m1} by the bits retired per step.
    always_comb begin
`ifdef BOOTH_RADIX4_EN
        w_acc_next = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
        w_q_next   = {w_sum[1:0], r_qreg[WIDTH-1:2]};
        w_qm1_next = r_qreg[1];
`else
        w_acc_next = {w_sum[AW-1], w_sum[AW-1:1]};
        w_q_next   = {w_sum[0], r_qreg[WIDTH-1:1]};
        w_qm1_next = r_qreg[0];
`endif
    end

    // Control FSM, iteration counter, datapath registers and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= {AW{1'b0}};
            r_mcand   <= {AW{1'b0}};
            r_qreg    <= {WIDTH{1'b0}};
            r_qm1     <= 1'b0;
            r_cnt     <= {CW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc   <= {AW{1'b0}};
                        r_mcand <= {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
                        r_qreg  <= multiplier;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CW'(ITER);
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_qreg <= w_q_next;
                    r_qm1 <= w_qm1_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_product <= {w_acc_next[WIDTH-1:0], w_q_next};
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=8 and WIDTH=16.
// Expected latencies follow BOOTH_RADIX4_EN; products come from plain M*Q.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int IT8  = 4;
    localparam int IT16 = 8;
`else
    localparam int IT8  = 8;
    localparam int IT16 = 16;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start8 = 1'b0;
    logic               start16 = 1'b0;
    logic signed [7:0]  m8 = 8'sd0;
    logic signed [7:0]  q8 = 8'sd0;
    logic signed [15:0] m16 = 16'sd0;
    logic signed [15:0] q16 = 16'sd0;
    logic               busy8, done8, busy16, done16;
    logic signed [15:0] p8;
    logic signed [31:0] p16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .multiplicand(m8), .multiplier(q8),
        .busy(busy8), .done(done8), .product(p8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16),
        .multiplicand(m16), .multiplier(q16),
        .busy(busy16), .done(done16), .product(p16)
    );

    task automatic drive(input bit wide, input bit st, input longint m, input longint q);
        if (wide) begin
            start16 = st; m16 = m[15:0]; q16 = q[15:0];
        end else begin
            start8 = st; m8 = m[7:0]; q8 = q[7:0];
        end
    endtask

    function automatic bit get_done(input bit wide);
        return wide ? done16 : done8;
    endfunction

    function automatic bit get_busy(input bit wide);
        return wide ? busy16 : busy8;
    endfunction

    function automatic longint get_prod(input bit wide);
        return wide ? longint'(p16) : longint'(p8);
    endfunction

    // Start one operation, then wait (bounded) for done; lat counts cycles
    // from the cycle after the accepting edge, bcnt the busy cycles seen.
    task automatic run_op(input bit wide, input longint m, input longint q,
                          output longint p, output int lat, output int bcnt);
        @(negedge clk); drive(wide, 1'b1, m, q);
        @(posedge clk);
        @(negedge clk); drive(wide, 1'b0, m, q);
        lat = 0;
        bcnt = 0;
        while (!get_done(wide) && lat < 200) begin
            if (get_busy(wide)) bcnt++;
            @(negedge clk);
            lat++;
        end
        p = get_prod(wide);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        total++; if (p8 !== 16'sd0) begin bad++; $display("FAIL reset_prod8 got=%0d exp=0", p8); end
        total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
        total++; if (done16 !== 1'b0) begin bad++; $display("FAIL reset_done16 got=%b exp=0", done16); end
        total++; if (p16 !== 32'sd0) begin bad++; $display("FAIL reset_prod16 got=%0d exp=0", p16); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        longint p;
        int lat, bcnt;
        run_op(1'b0, 127, -1, p, lat, bcnt);
        total++; if (lat !== IT8) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, IT8); end
        total++; if (bcnt !== IT8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bcnt, IT8); end
        total++; if (p !== -127) begin bad++; $display("FAIL basic_product got=%0d exp=-127", p); end
        @(negedge clk);
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done8); end
        total++; if (p8 !== -16'sd127) begin bad++; $display("FAIL basic_product_hold got=%0d exp=-127", p8); end
    endtask

    task automatic test_pairs();
        longint ma[5] = '{-128, -128, 0, 5, 64};
        longint qa[5] = '{-128, 1, 85, 5, 2};
        longint ea[5] = '{16384, -128, 0, 25, 128};
        longint p;
        int lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, ma[i], qa[i], p, lat, bcnt);
            total++;
            if (p !== ea[i] || lat !== IT8) begin
                bad++;
                $display("FAIL pair_%0d got=%0d lat=%0d exp=%0d lat=%0d", i, p, lat, ea[i], IT8);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk); drive(1'b0, 1'b1, 3, -7);
        @(posedge clk);
        @(negedge clk); drive(1'b0, 1'b1, -9, 11);
        lat = 0;
        while (!done8 && lat < 200) begin @(negedge clk); lat++; end
        total++; if (lat !== IT8) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, IT8); end
        total++; if (p8 !== -16'sd21) begin bad++; $display("FAIL b2b_first_product got=%0d exp=-21", p8); end
        @(negedge clk);
        total++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            bad++; $display("FAIL b2b_reaccept got busy=%b done=%b exp busy=1 done=0", busy8, done8);
        end
        drive(1'b0, 1'b0, -9, 11);
        lat = 0;
        while (!done8 && lat < 200) begin @(negedge clk); lat++; end
        total++; if (lat !== IT8) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, IT8); end
        total++; if (p8 !== -16'sd99) begin bad++; $display("FAIL b2b_second_product got=%0d exp=-99", p8); end
    endtask

    task automatic test_ignore_start();
        int npulse = 0;
        longint pd = 0;
        @(negedge clk); drive(1'b0, 1'b1, 10, 10);
        @(posedge clk);
        @(negedge clk); drive(1'b0, 1'b0, 10, 10);
        @(negedge clk);
        @(negedge clk); drive(1'b0, 1'b1, 2, 2);
        @(negedge clk); drive(1'b0, 1'b0, 2, 2);
        for (int i = 0; i < 3 * IT8; i++) begin
            if (done8) begin npulse++; pd = longint'(p8); end
            @(negedge clk);
        end
        total++; if (npulse !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", npulse); end
        total++; if (pd !== 100) begin bad++; $display("FAIL ignore_product got=%0d exp=100", pd); end
        total++; if (p8 !== 16'sd100) begin bad++; $display("FAIL ignore_product_hold got=%0d exp=100", p8); end
    endtask

    task automatic test_reset_mid();
        int npulse = 0;
        longint p;
        int lat, bcnt;
        @(negedge clk); drive(1'b0, 1'b1, 7, 9);
        @(posedge clk);
        @(negedge clk); drive(1'b0, 1'b0, 7, 9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done8); end
        total++; if (p8 !== 16'sd0) begin bad++; $display("FAIL midrst_product got=%0d exp=0", p8); end
        for (int i = 0; i < 2 * IT8; i++) begin
            if (done8) npulse++;
            @(negedge clk);
        end
        total++; if (npulse !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", npulse); end
        run_op(1'b0, 6, -6, p, lat, bcnt);
        total++; if (p !== -36 || lat !== IT8) begin
            bad++; $display("FAIL midrst_fresh got=%0d lat=%0d exp=-36 lat=%0d", p, lat, IT8);
        end
    endtask

    task automatic test_w16();
        longint p;
        int lat, bcnt;
        run_op(1'b1, -32768, -32768, p, lat, bcnt);
        total++; if (p !== 1073741824) begin bad++; $display("FAIL w16_minmin got=%0d exp=1073741824", p); end
        total++; if (lat !== IT16) begin bad++; $display("FAIL w16_latency got=%0d exp=%0d", lat, IT16); end
        total++; if (bcnt !== IT16) begin bad++; $display("FAIL w16_busy_cycles got=%0d exp=%0d", bcnt, IT16); end
        run_op(1'b1, 32767, -32768, p, lat, bcnt);
        total++; if (p !== -1073709056) begin bad++; $display("FAIL w16_maxmin got=%0d exp=-1073709056", p); end
    endtask

    task automatic test_random();
        longint m, q, p, exp_p;
        int lat, bcnt;
        for (int i = 0; i < 1000; i++) begin
            m = longint'($urandom_range(0, 65535)) - 32768;
            q = longint'($urandom_range(0, 65535)) - 32768;
            exp_p = m * q;
            run_op(1'b1, m, q, p, lat, bcnt);
            total++;
            if (p !== exp_p || lat !== IT16) begin
                bad++;
                $display("FAIL rand16 m=%0d q=%0d got=%0d lat=%0d exp=%0d lat=%0d", m, q, p, lat, exp_p, IT16);
            end
        end
        for (int i = 0; i < 200; i++) begin
            m = longint'($urandom_range(0, 255)) - 128;
            q = longint'($urandom_range(0, 255)) - 128;
            exp_p = m * q;
            run_op(1'b0, m, q, p, lat, bcnt);
            total++;
            if (p !== exp_p || lat !== IT8) begin
                bad++;
                $display("FAIL rand8 m=%0d q=%0d got=%0d lat=%0d exp=%0d lat=%0d", m, q, p, lat, exp_p, IT8);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_pairs();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_w16();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
